// File: rtl/mux_serializer.sv
// mux_serializer: 4-bit parallel-to-serial sequencer driving a 4:1 bit mux.
// Holds the word on mux_d, steps mux_s, and forwards mux_o as a serial stream.
module mux_serializer #(
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_data,
   output logic [1:0] mux_s,
   output logic [3:0] mux_d,
   input  logic       mux_o,
   output logic       ser_valid,
   output logic       ser_bit,
   output logic       ser_last,
   input  logic       ser_ready
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic [3:0] word_q, word_d;
   logic       last_beat;

   assign last_beat = (state_q == SHIFT) && (cnt_q == 2'd3);

   // Handshake and mux-facing outputs derived from the registered state.
   always_comb begin
      in_ready  = !rst && ((state_q == IDLE) || (last_beat && ser_ready));
      ser_valid = (state_q == SHIFT);
      ser_last  = last_beat;
      ser_bit   = mux_o;
      mux_d     = word_q;
      mux_s     = 2'd0;
      if (state_q == SHIFT) begin
         mux_s = MSB_FIRST ? (2'd3 - cnt_q) : cnt_q;
      end
   end

   // Next-state logic: load on accept, advance on each accepted beat.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               word_d  = in_data;
               cnt_d   = 2'd0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (ser_ready) begin
               if (cnt_q != 2'd3) begin
                  cnt_d = cnt_q + 2'd1;
               end else if (in_valid) begin
                  word_d = in_data;
                  cnt_d  = 2'd0;
               end else begin
                  state_d = IDLE;
                  cnt_d   = 2'd0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 2'd0;
         end
      endcase
   end

   // State registers with synchronous reset discarding any partial word.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         word_q  <= 4'b0000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
      end
   end

endmodule

// File: tb/tb_mux_serializer.sv
// tb_mux_serializer: scoreboard bench for both select orders.
// Each DUT drives its own behavioural 4:1 mux.
module tb_mux_serializer;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [3:0] in_data;
   logic       ser_ready;

   logic       in_ready0, in_ready1;
   logic [1:0] mux_s0, mux_s1;
   logic [3:0] mux_d0, mux_d1;
   logic       mux_o0, mux_o1;
   logic       ser_valid0, ser_valid1;
   logic       ser_bit0, ser_bit1;
   logic       ser_last0, ser_last1;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       b;
      logic [1:0] s;
      logic       last;
   } beat_t;

   beat_t      q0[$];
   beat_t      q1[$];
   logic [3:0] exp_word;

   always #5 clk = ~clk;

   assign mux_o0 = mux_d0[mux_s0];
   assign mux_o1 = mux_d1[mux_s1];

   mux_serializer #(.MSB_FIRST(1'b0)) dut0 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
      .mux_s(mux_s0), .mux_d(mux_d0), .mux_o(mux_o0),
      .ser_valid(ser_valid0), .ser_bit(ser_bit0),
      .ser_last(ser_last0), .ser_ready(ser_ready)
   );

   mux_serializer #(.MSB_FIRST(1'b1)) dut1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
      .mux_s(mux_s1), .mux_d(mux_d1), .mux_o(mux_o1),
      .ser_valid(ser_valid1), .ser_bit(ser_bit1),
      .ser_last(ser_last1), .ser_ready(ser_ready)
   );

   task automatic chk(input string tag, input logic [3:0] got,
                      input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic monitor();
      logic  busy, exp_rdy;
      beat_t it;
      busy    = (q0.size() != 0);
      exp_rdy = !rst && (!busy || (q0.size() == 1 && ser_ready));
      chk("in_ready0", {3'b0, in_ready0}, {3'b0, exp_rdy});
      chk("in_ready1", {3'b0, in_ready1}, {3'b0, exp_rdy});
      chk("ser_valid0", {3'b0, ser_valid0}, {3'b0, busy});
      chk("ser_valid1", {3'b0, ser_valid1}, {3'b0, busy});
      chk("mux_d0", mux_d0, exp_word);
      chk("mux_d1", mux_d1, exp_word);
      if (busy) begin
         it = q0[0];
         chk("bit0", {3'b0, ser_bit0}, {3'b0, it.b});
         chk("sel0", {2'b0, mux_s0}, {2'b0, it.s});
         chk("last0", {3'b0, ser_last0}, {3'b0, it.last});
         it = q1[0];
         chk("bit1", {3'b0, ser_bit1}, {3'b0, it.b});
         chk("sel1", {2'b0, mux_s1}, {2'b0, it.s});
         chk("last1", {3'b0, ser_last1}, {3'b0, it.last});
      end else begin
         chk("idle_sel0", {2'b0, mux_s0}, 4'd0);
         chk("idle_sel1", {2'b0, mux_s1}, 4'd0);
         chk("idle_last0", {3'b0, ser_last0}, 4'd0);
         chk("idle_last1", {3'b0, ser_last1}, 4'd0);
      end
      if (rst) begin
         q0.delete();
         q1.delete();
         exp_word = 4'b0000;
      end else begin
         if (busy && ser_ready) begin
            void'(q0.pop_front());
            void'(q1.pop_front());
         end
         if (in_valid && exp_rdy) begin
            exp_word = in_data;
            for (int i = 0; i < 4; i++) begin
               q0.push_back('{b: in_data[i], s: 2'(i), last: (i == 3)});
               q1.push_back('{b: in_data[3-i], s: 2'(3-i), last: (i == 3)});
            end
         end
      end
   endtask

   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         monitor();
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [3:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      exp_word  = 4'b0000;
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_data   = 4'hE;
      ser_ready = 1'b1;
      @(posedge clk);
      #1;
      tick(2);
      rst      = 1'b0;
      in_valid = 1'b0;
      tick();

      send(4'b1011);
      tick(5);

      send(4'b0010);
      tick(5);

      in_valid = 1'b1;
      in_data  = 4'hA;
      tick();
      in_data  = 4'h5;
      tick(4);
      in_valid = 1'b0;
      tick(5);

      send(4'b0110);
      tick(2);
      ser_ready = 1'b0;
      tick(3);
      ser_ready = 1'b1;
      tick(3);

      send(4'hF);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_valid0", {3'b0, ser_valid0}, 4'd0);
      chk("rst_mux_d0", mux_d0, 4'd0);
      chk("rst_mux_s1", {2'b0, mux_s1}, 4'd0);
      tick();
      send(4'h3);
      tick(5);

      send(4'h9);
      tick(3);
      ser_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 4'hC;
      tick(2);
      ser_ready = 1'b1;
      tick();
      in_valid  = 1'b0;
      tick(5);

      for (int r = 0; r < 120; r++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 4'($urandom_range(0, 15));
         ser_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      in_valid  = 1'b0;
      ser_ready = 1'b1;
      tick(6);
      chk("drain0", 4'(q0.size()), 4'd0);
      chk("drain1", 4'(q1.size()), 4'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
